// File: rtl/face_instr_issuer_if.sv
// FACE instruction port bundle: run control from the host side, program BRAM
// read port, and the instruction/busy pair towards the FACE accelerator.
// master = the issuer, slave = the surrounding host/BRAM/FACE environment.
interface face_instr_issuer_if #(
  parameter int ADDR_W = 15,
  parameter int LEN_W  = 10
);
  logic              start;
  logic [ADDR_W-1:0] prog_base;
  logic [LEN_W-1:0]  prog_len;
  logic              abort;
  logic              prog_ren;
  logic [ADDR_W-1:0] prog_addr;
  logic [31:0]       prog_rdata;
  logic              face_busy;
  logic [31:0]       instr;
  logic              running;
  logic              done;
  logic [LEN_W-1:0]  issue_cnt;
  logic              timeout_err;

  modport master (
    input  start, prog_base, prog_len, abort, prog_rdata, face_busy,
    output prog_ren, prog_addr, instr, running, done, issue_cnt, timeout_err
  );

  modport slave (
    output start, prog_base, prog_len, abort, prog_rdata, face_busy,
    input  prog_ren, prog_addr, instr, running, done, issue_cnt, timeout_err
  );
endinterface

// File: rtl/face_instr_issuer.sv
// face_instr_issuer: walks a program in BRAM and hands each 32-bit word to
// FACE for exactly one cycle, padding with NOPs and waiting for face_busy to
// drop before the next word. Optional busy watchdog: FACE_ISSUER_TIMEOUT_EN.
module face_instr_issuer #(
  parameter int ADDR_W         = 15,
  parameter int LEN_W          = 10,
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  face_instr_issuer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPTURE, S_ISSUE, S_SETTLE, S_WAIT, S_DONE
  } state_t;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("face_instr_issuer: SETTLE_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  // issue_cnt doubles as the word index: both restart at 0 and step together
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       instr_q, instr_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic              start_acc;
  logic              to_fire;

  // abort outranks start, and start only counts from IDLE
  assign start_acc = (state_q == S_IDLE) && bus.start && !bus.abort;

`ifdef FACE_ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_err_q, to_err_d;

  // watchdog: count busy cycles spent in WAIT, fire on the limit
  always_comb begin
    to_cnt_d = '0;
    to_fire  = 1'b0;
    to_err_d = to_err_q;
    if (state_q == S_WAIT && bus.face_busy && !bus.abort) begin
      if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) to_fire = 1'b1;
      else                                     to_cnt_d = to_cnt_q + 1'b1;
    end
    if (start_acc) to_err_d = 1'b0;
    if (to_fire)   to_err_d = 1'b1;
  end

  // watchdog registers
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign bus.timeout_err = to_err_q;
`else
  assign to_fire         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
    running_d = running_q;
    done_d    = 1'b0;
    settle_d  = settle_q;
    if (bus.abort) begin
      // kill the run silently; issue_cnt keeps what was already issued
      if (state_q != S_IDLE) begin
        state_d   = S_IDLE;
        instr_d   = '0;
        running_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.start) begin
          base_d    = bus.prog_base;
          len_d     = bus.prog_len;
          cnt_d     = '0;
          running_d = 1'b1;
          state_d   = (bus.prog_len == '0) ? S_DONE : S_FETCH;
        end
        S_FETCH:   state_d = S_CAPTURE;
        S_CAPTURE: begin
          instr_d = bus.prog_rdata;
          state_d = S_ISSUE;
        end
        S_ISSUE: begin
          // word is on the bus this cycle only; NOP follows
          instr_d  = '0;
          cnt_d    = cnt_q + 1'b1;
          settle_d = '0;
          state_d  = S_SETTLE;
        end
        S_SETTLE: begin
          // FACE busy is registered, so it cannot reflect this word yet
          if (settle_q == SW'(SETTLE_CYCLES - 1)) state_d  = S_WAIT;
          else                                    settle_d = settle_q + 1'b1;
        end
        S_WAIT: begin
          if (to_fire)             state_d = S_DONE;
          else if (!bus.face_busy) state_d = (cnt_q == len_q) ? S_DONE : S_FETCH;
        end
        S_DONE: begin
          done_d    = 1'b1;
          running_d = 1'b0;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      instr_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      instr_q   <= instr_d;
      running_q <= running_d;
      done_q    <= done_d;
      settle_q  <= settle_d;
    end
  end

  // BRAM read port is decoded straight from state so data lands for CAPTURE
  assign bus.prog_ren  = (state_q == S_FETCH);
  assign bus.prog_addr = (state_q == S_FETCH) ? base_q + ADDR_W'(cnt_q) : '0;
  assign bus.instr     = instr_q;
  assign bus.running   = running_q;
  assign bus.done      = done_q;
  assign bus.issue_cnt = cnt_q;

endmodule
